// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, requester ids and length codes
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_MA = 1'b1;
  localparam logic [1:0] LEN_WORD = 2'd3;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the shared memory command port
interface mem_port_arbiter_if #(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
);
  logic               if_req;
  logic [MADDR_L-1:0] if_addr;
  logic               if_ack;
  logic [DATA_L-1:0]  if_rdata;
  logic               ma_req;
  logic               ma_we;
  logic [1:0]         ma_len;
  logic [MADDR_L-1:0] ma_addr;
  logic [DATA_L-1:0]  ma_wdata;
  logic               ma_ack;
  logic [DATA_L-1:0]  ma_rdata;
  logic               mem_en;
  logic               mem_we;
  logic [1:0]         mem_len;
  logic [MADDR_L-1:0] mem_addr;
  logic [DATA_L-1:0]  mem_wdata;
  logic [DATA_L-1:0]  mem_rdata;
  logic               mem_done;
  logic               mem_timeout;
  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_len, ma_addr, ma_wdata, mem_rdata, mem_done,
    output if_ack, if_rdata, ma_ack, ma_rdata, mem_en, mem_we, mem_len, mem_addr, mem_wdata,
           mem_timeout
  );
  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_len, ma_addr, ma_wdata, mem_rdata, mem_done,
    input  if_ack, if_rdata, ma_ack, ma_rdata, mem_en, mem_we, mem_len, mem_addr, mem_wdata,
           mem_timeout
  );
endinterface

// File: rtl/mem_port_arbiter_arb_prio_starve.sv
// arb_prio_starve: MA-priority pick with a starvation counter that forces an IF grant
module arb_prio_starve
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic grant_i,
  input  logic if_req_i,
  input  logic ma_req_i,
  output logic win_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       at_max;
  assign at_max = cnt_q == 4'(STARVE_MAX);
  assign win_o  = (ma_req_i && !(if_req_i && at_max)) ? REQ_MA : REQ_IF;
  // count MA grants that bypass a waiting IF; any other grant clears it
  always_comb
    cnt_d = !grant_i ? cnt_q :
            (win_o == REQ_MA && if_req_i) ? (at_max ? cnt_q : cnt_q + 4'd1) : '0;
  // starvation counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MA, one transaction at a time
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MADDR_L    = 32,
  parameter int DATA_L     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  state_e             state_q, state_d;
  logic               win, grant, done, expire, finish, capture;
  logic               id_q, id_d, we_q, we_d, mem_en_q, mem_en_d;
  logic               if_ack_q, if_ack_d, ma_ack_q, ma_ack_d, tmo_q, tmo_d;
  logic [1:0]         len_q, len_d;
  logic [MADDR_L-1:0] addr_q, addr_d;
  logic [DATA_L-1:0]  wdata_q, wdata_d, if_rdata_q, if_rdata_d, ma_rdata_q, ma_rdata_d, rd_val;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  assign grant   = state_q == S_IDLE && (bus.if_req || bus.ma_req);
  assign done    = state_q == S_WAIT && bus.mem_done;
  assign expire  = state_q == S_WAIT && !bus.mem_done && wait_cnt_q == 8'(TIMEOUT - 1);
  assign finish  = done || expire;
  assign capture = expire || (done && !we_q);
  assign rd_val  = done ? bus.mem_rdata : '0;
  arb_prio_starve #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .grant_i  (grant),
    .if_req_i (bus.if_req),
    .ma_req_i (bus.ma_req),
    .win_o    (win)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  // IDLE -> ISSUE -> WAIT -> DONE -> IDLE; WAIT exits on completion or timeout
  always_comb
    state_d = state_q == S_IDLE  ? (grant ? S_ISSUE : S_IDLE) :
              state_q == S_ISSUE ? S_WAIT :
              state_q == S_WAIT  ? (finish ? S_DONE : S_WAIT) : S_IDLE;
  // next values of the registered outputs and the latched command
  always_comb begin
    id_d       = grant ? win : id_q;
    we_d       = grant ? (win == REQ_MA && bus.ma_we) : we_q;
    len_d      = grant ? (win == REQ_MA ? bus.ma_len : LEN_WORD) : len_q;
    addr_d     = grant ? (win == REQ_MA ? bus.ma_addr : bus.if_addr) : addr_q;
    wdata_d    = grant ? (win == REQ_MA ? bus.ma_wdata : '0) : wdata_q;
    mem_en_d   = grant;
    wait_cnt_d = state_q == S_ISSUE ? '0 : state_q == S_WAIT ? wait_cnt_q + 8'd1 : wait_cnt_q;
    if_ack_d   = finish && id_q == REQ_IF;
    ma_ack_d   = finish && id_q == REQ_MA;
    if_rdata_d = (capture && id_q == REQ_IF) ? rd_val : if_rdata_q;
    ma_rdata_d = (capture && id_q == REQ_MA) ? rd_val : ma_rdata_q;
    tmo_d      = tmo_q || expire;
  end
  // output and command registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_q       <= REQ_IF;
      we_q       <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      wait_cnt_q <= '0;
      if_ack_q   <= 1'b0;
      ma_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      id_q       <= id_d;
      we_q       <= we_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= mem_en_d;
      wait_cnt_q <= wait_cnt_d;
      if_ack_q   <= if_ack_d;
      ma_ack_q   <= ma_ack_d;
      if_rdata_q <= if_rdata_d;
      ma_rdata_q <= ma_rdata_d;
      tmo_q      <= tmo_d;
    end
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_len     = len_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.ma_ack      = ma_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.ma_rdata    = ma_rdata_q;
  assign bus.mem_timeout = tmo_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, scoreboarded commands and acks
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;
  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } ack_t;
  typedef struct {
    logic        who;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    int          delay;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.MADDR_L(32), .DATA_L(32)) mif ();
  mem_port_arbiter #(.MADDR_L(32), .DATA_L(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_delay = 1;
  logic        dbl_done = 1'b0;
  logic        auto_done = 1'b0;
  logic        stray_done = 1'b0;
  logic [31:0] resp_data = '0;
  cmd_t        cmd_q[$];
  ack_t        ack_q[$];
  cmd_t        mc;
  ack_t        ma;
  vec_t        tab[7];
  assign mif.mem_done  = auto_done | stray_done;
  assign mif.mem_rdata = resp_data;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (mif.mem_en) begin
        if (cmd_q.size() == 0) chk("unexpected mem_en", 32'd1, 32'd0);
        else begin
          mc = cmd_q.pop_front();
          chk("mem_addr", mif.mem_addr, mc.addr);
          chk("mem_we", 32'(mif.mem_we), 32'(mc.we));
          chk("mem_len", 32'(mif.mem_len), 32'(mc.len));
          chk("mem_wdata", mif.mem_wdata, mc.wdata);
        end
      end
      if (mif.if_ack || mif.ma_ack) begin
        if (ack_q.size() == 0) chk("unexpected ack", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
        else begin
          ma = ack_q.pop_front();
          chk("ack_who", 32'({mif.ma_ack, mif.if_ack}), ma.who ? 32'd2 : 32'd1);
          chk("ack_rdata", ma.who ? mif.ma_rdata : mif.if_rdata, ma.rdata);
        end
      end
    end
  initial forever begin
    @(negedge clk);
    if (rst_n && mif.mem_en && mem_delay != 0) begin
      repeat (mem_delay) @(posedge clk);
      #1 auto_done = 1'b1;
      @(posedge clk);
      if (dbl_done) @(posedge clk);
      #1 auto_done = 1'b0;
    end
  end
  task automatic expect_txn(input logic who, input logic we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata);
    cmd_t c;
    ack_t a;
    c.we = who & we;
    c.len = who ? len : LEN_WORD;
    c.addr = addr;
    c.wdata = who ? wdata : 32'd0;
    a.who = who;
    a.rdata = rdata;
    cmd_q.push_back(c);
    ack_q.push_back(a);
  endtask
  task automatic run_vec(input vec_t v);
    int   n;
    logic hold_ok, got;
    logic [31:0] ea;
    expect_txn(v.who, v.we, v.len, v.addr, v.wdata, v.exp_rdata);
    mem_delay = v.delay;
    resp_data = v.rdata;
    mif.ma_we = v.we;
    mif.ma_len = v.len;
    mif.ma_addr = v.addr;
    mif.ma_wdata = v.wdata;
    mif.if_addr = v.addr;
    if (v.who) mif.ma_req = 1'b1;
    else mif.if_req = 1'b1;
    ea = v.addr;
    n = 0;
    hold_ok = 1'b1;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = mif.if_ack | mif.ma_ack;
      if (mif.mem_addr !== ea || mif.mem_we !== (v.who & v.we) ||
          mif.mem_len !== (v.who ? v.len : LEN_WORD) ||
          mif.mem_wdata !== (v.who ? v.wdata : 32'd0)) hold_ok = 1'b0;
    end
    chk("ack latency", 32'(n), v.delay == 0 ? 32'd10 : 32'(v.delay + 2));
    chk("command hold", 32'(hold_ok), 32'd1);
    mif.ma_req = 1'b0;
    mif.if_req = 1'b0;
    @(negedge clk);
    chk("ack pulse width", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
    chk("rdata held", v.who ? mif.ma_rdata : mif.if_rdata, v.exp_rdata);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, if_pos, cyc, n;
    vec_t tv;
    tab[0] = '{1'b1, 1'b0, 2'd3, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    tab[1] = '{1'b1, 1'b1, 2'd1, 32'h40, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF, 3};
    tab[2] = '{1'b0, 1'b1, 2'd1, 32'h200, 32'hBAD0BAD0, 32'hCAFEF00D, 32'hCAFEF00D, 2};
    tab[3] = '{1'b1, 1'b0, 2'd2, 32'h104, 32'h99999999, 32'h0BADF00D, 32'h0BADF00D, 1};
    tab[4] = '{1'b0, 1'b1, 2'd0, 32'h300, 32'hBAD0BAD0, 32'h11223344, 32'h11223344, 5};
    tab[5] = '{1'b1, 1'b1, 2'd0, 32'h8, 32'hA5A5A5A5, 32'h77777777, 32'h0BADF00D, 7};
    tab[6] = '{1'b0, 1'b0, 2'd2, 32'h204, 32'h5A5A5A5A, 32'h87654321, 32'h87654321, 1};
    mif.if_req = 1'b0;
    mif.if_addr = '0;
    mif.ma_req = 1'b0;
    mif.ma_we = 1'b0;
    mif.ma_len = '0;
    mif.ma_addr = '0;
    mif.ma_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset mem_en", 32'(mif.mem_en), 32'd0);
    chk("reset acks", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
    chk("reset mem_addr", mif.mem_addr, 32'd0);
    chk("reset mem_timeout", 32'(mif.mem_timeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_vec(tab[i]);
    chk("no timeout yet", 32'(mif.mem_timeout), 32'd0);
    tv = '{1'b1, 1'b0, 2'd3, 32'h500, 32'h0, 32'h0, 32'h0, 0};
    run_vec(tv);
    chk("timeout flag set", 32'(mif.mem_timeout), 32'd1);
    tv = '{1'b0, 1'b0, 2'd3, 32'h600, 32'h0, 32'h13572468, 32'h13572468, 1};
    run_vec(tv);
    chk("timeout flag sticky", 32'(mif.mem_timeout), 32'd1);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray done no mem_en", 32'(mif.mem_en), 32'd0);
    chk("stray done no ack", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
    dbl_done = 1'b1;
    tv = '{1'b1, 1'b0, 2'd3, 32'h700, 32'h0, 32'h2468ACE0, 32'h2468ACE0, 1};
    run_vec(tv);
    dbl_done = 1'b0;
    @(negedge clk);
    chk("double done no extra ack", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
    mem_delay = 1;
    resp_data = 32'h5555AAAA;
    for (int i = 0; i < 4; i++) expect_txn(1'b1, 1'b0, 2'd3, 32'h900, 32'h0F0F0F0F, 32'h5555AAAA);
    expect_txn(1'b0, 1'b0, 2'd3, 32'hA00, 32'h0, 32'h5555AAAA);
    expect_txn(1'b1, 1'b0, 2'd3, 32'h900, 32'h0F0F0F0F, 32'h5555AAAA);
    mif.ma_we = 1'b0;
    mif.ma_len = 2'd3;
    mif.ma_addr = 32'h900;
    mif.ma_wdata = 32'h0F0F0F0F;
    mif.if_addr = 32'hA00;
    mif.ma_req = 1'b1;
    mif.if_req = 1'b1;
    k = 0;
    if_pos = 0;
    cyc = 0;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mif.if_ack) begin
        k++;
        if_pos = k;
        mif.if_req = 1'b0;
      end
      if (mif.ma_ack) begin
        k++;
        if (k == 6) mif.ma_req = 1'b0;
      end
    end
    mif.ma_req = 1'b0;
    mif.if_req = 1'b0;
    chk("contention grant count", 32'(k), 32'd6);
    chk("IF grant slot", 32'(if_pos), 32'd5);
    @(negedge clk);
    mem_delay = 0;
    expect_txn(1'b0, 1'b0, 2'd3, 32'h700, 32'h0, 32'h0);
    void'(ack_q.pop_back());
    mif.if_addr = 32'h700;
    mif.if_req = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mem_en", 32'(mif.mem_en), 32'd0);
    chk("async reset mem_addr", mif.mem_addr, 32'd0);
    chk("async reset mem_len", 32'(mif.mem_len), 32'd0);
    chk("async reset ma_rdata", mif.ma_rdata, 32'd0);
    chk("async reset if_rdata", mif.if_rdata, 32'd0);
    chk("async reset mem_timeout", 32'(mif.mem_timeout), 32'd0);
    mem_delay = 1;
    resp_data = 32'h0A0B0C0D;
    expect_txn(1'b0, 1'b0, 2'd3, 32'h700, 32'h0, 32'h0A0B0C0D);
    @(negedge clk);
    chk("no ack during reset", 32'({mif.ma_ack, mif.if_ack}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mem_en one cycle after release", 32'(mif.mem_en), 32'd1);
    n = 1;
    while (!mif.if_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("post-reset IF latency", 32'(n), 32'd3);
    mif.if_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("cmd queue drained", 32'(cmd_q.size()), 32'd0);
    chk("ack queue drained", 32'(ack_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (IF, read-only) and the memory-access stage (MA, read/write).
- Sits between the pipeline stages and the memory model.
- Latches one transaction, drives the memory port, waits for completion, then returns data and a one-cycle ack to the winner.
- MA has priority; a starvation counter guarantees IF progress. A timeout flags a hung memory.

Parameters:
- MADDR_L, 32, memory address width
- DATA_L, 32, data width
- STARVE_MAX, 4, consecutive MA grants allowed while IF is waiting (1..15)
- TIMEOUT, 255, WAIT cycles before abort (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF read request, level, held until if_ack
- if_addr  in  MADDR_L  IF read address (word read, len=3)
- if_ack  out  1  one-cycle completion pulse to IF
- if_rdata  out  DATA_L  IF read data, valid while if_ack=1 and held after
- ma_req  in  1  MA request, level, held until ma_ack
- ma_we  in  1  1=write, 0=read
- ma_len  in  2  access length code passed to memory
- ma_addr  in  MADDR_L  MA address
- ma_wdata  in  DATA_L  MA write data
- ma_ack  out  1  one-cycle completion pulse to MA
- ma_rdata  out  DATA_L  MA read data, valid while ma_ack=1 and held after
- mem_en  out  1  one-cycle memory command strobe
- mem_we  out  1  command is a write
- mem_len  out  2  command length
- mem_addr  out  MADDR_L  command address
- mem_wdata  out  DATA_L  command write data
- mem_rdata  in  DATA_L  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse
- mem_timeout  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state IDLE, starve_cnt=0, wait_cnt=0; any in-flight transaction is dropped with no ack.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If no request, stay.
  - Else choose a winner:
    - MA wins if ma_req and not (if_req and starve_cnt==STARVE_MAX).
    - Otherwise IF wins if if_req.
  - Latch winner id, addr, we, len and wdata into command regs (IF: we=0, len=3, wdata=0). Go to ISSUE.
- starve_cnt:
  - On an MA grant with if_req=1: saturating increment.
  - On an IF grant, or an MA grant with if_req=0: cleared.
- ISSUE: mem_en=1 for exactly this cycle; mem_we/len/addr/wdata drive the latched values and hold them through WAIT. Clear wait_cnt. Go to WAIT.
- WAIT:
  - mem_done is ignored in ISSUE and sampled only in WAIT.
  - On mem_done=1: capture mem_rdata into the winner's rdata reg (reads only; on writes the rdata reg is unchanged). Go to DONE.
  - Else increment wait_cnt. If wait_cnt reaches TIMEOUT: set mem_timeout (sticky until reset), set the winner's rdata to 0, go to DONE.
- DONE:
  - Winner's ack=1 for this cycle only. Requests are ignored this cycle.
  - Go to IDLE. The requester must drop or renew req in the cycle after ack.
- Latency:
  - req seen in IDLE at cycle 0 → mem_en at cycle 1 → mem_done earliest at cycle 2 → ack at cycle 3.
  - General case: ack = mem_done cycle + 1.
- Throughput: back-to-back grants are possible; IDLE follows DONE immediately.
- Simultaneous ma_req and if_req with starve_cnt<STARVE_MAX: MA wins and IF waits, with its req held.
- Requests that drop before ack are a protocol violation; the latched transaction still completes.
- A mem_done arriving in IDLE/ISSUE/DONE is ignored.

Decomposition:
- Shared package: state encoding (2-bit IDLE/ISSUE/WAIT/DONE), requester id constants (REQ_IF=0, REQ_MA=1), length code LEN_WORD=3.
- One natural sub-module: arb_prio_starve (priority pick + starve_cnt, purely IDLE-time logic). The FSM and datapath registers stay in the top level.

Test Plan:
- MA read alone: ma_req, addr=0x100, len=3; mem_done 1 cycle after mem_en with rdata=0xDEADBEEF → mem_en at c1 with addr 0x100 and we=0; ma_ack at c3 with ma_rdata=0xDEADBEEF.
- MA write: ma_we=1, addr=0x40, wdata=0x12345678, len=1; memory done 3 cycles after mem_en → mem_we=1, mem_wdata=0x12345678, mem_len=1 held until done; ma_ack 1 cycle after done; ma_rdata unchanged.
- Contention/starvation: both requesting continuously, STARVE_MAX=4, MA re-requesting after each ack → grants go MA,MA,MA,MA,IF,MA…; IF is acked on the 5th grant.
- Timeout: TIMEOUT=8, mem_done never asserted → the winner's ack comes after 8 WAIT cycles with rdata=0; mem_timeout=1 and stays 1; the next transaction still completes normally.
- Async reset mid-WAIT: pull rst_n low in WAIT → all outputs 0 immediately, no ack; after release with if_req held → fresh IF transaction, mem_en 1 cycle after reset release.
- Stray mem_done in IDLE, and a second mem_done in DONE → no state change, no extra ack.
